// File: rtl/latch_strobe_tx.sv
// latch_strobe_tx: drives d/g/clr for a downstream transparent latch with setup, gate and hold phasing.
// Words arrive over valid/ready; clear requests are queued and serviced only from IDLE.
module latch_strobe_tx #(
    parameter int WIDTH = 8,
    parameter int SETUP = 2,
    parameter int PULSE = 3,
    parameter int HOLD  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr_req,
    output logic [WIDTH-1:0] d,
    output logic             g,
    output logic             clr,
    output logic             busy
);
    localparam int MAXC = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD) : ((PULSE > HOLD) ? PULSE : HOLD);
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_GATE, S_HOLD, S_CLEAR} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic g_q, g_d, clr_q, clr_d, clr_pend_q, clr_pend_d;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        d_d = d_q;
        clr_pend_d = clr_pend_q | clr_req;
        case (state_q)
            S_IDLE:
                if (clr_pend_q || clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d = CW'(PULSE - 1);
                    clr_pend_d = 1'b0;
                end else if (in_valid) begin
                    state_d = S_SETUP;
                    cnt_d = CW'(SETUP - 1);
                    d_d = in_data;
                end
            S_SETUP:
                if (cnt_q == '0) begin
                    state_d = S_GATE;
                    cnt_d = CW'(PULSE - 1);
                end else cnt_d = cnt_q - 1'b1;
            S_GATE:
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d = CW'(HOLD - 1);
                end else cnt_d = cnt_q - 1'b1;
            S_HOLD, S_CLEAR:
                if (cnt_q == '0) state_d = S_IDLE;
                else cnt_d = cnt_q - 1'b1;
            default: state_d = S_IDLE;
        endcase
        // Strobes are registered copies of the next state, so g and clr can never overlap.
        g_d = state_d == S_GATE;
        clr_d = state_d == S_CLEAR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            d_q <= '0;
            g_q <= 1'b0;
            clr_q <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            d_q <= d_d;
            g_q <= g_d;
            clr_q <= clr_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    assign in_ready = (state_q == S_IDLE) && !clr_pend_q && !clr_req && !rst;
    assign d = d_q;
    assign g = g_q;
    assign clr = clr_q;
    assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_latch_strobe_tx.sv
// tb_latch_strobe_tx: directed bench for a default and a SETUP=PULSE=HOLD=1 instance,
// checked every cycle against a phase-timeline model plus literal expectations.
module tb_latch_strobe_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] din[2];
    logic [7:0] dq[2];
    logic vin[2], creq[2], rdy[2], gq[2], cq[2], bq[2];
    int checks = 0;
    int failures = 0;

    latch_strobe_tx u0 (
        .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vin[0]), .in_ready(rdy[0]),
        .clr_req(creq[0]), .d(dq[0]), .g(gq[0]), .clr(cq[0]), .busy(bq[0])
    );
    latch_strobe_tx #(.WIDTH(8), .SETUP(1), .PULSE(1), .HOLD(1)) u1 (
        .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vin[1]), .in_ready(rdy[1]),
        .clr_req(creq[1]), .d(dq[1]), .g(gq[1]), .clr(cq[1]), .busy(bq[1])
    );

    // Model: mode 0 idle, 1 transfer, 2 clear; e = edges elapsed since the operation began.
    int sp[2] = '{2, 1};
    int pp[2] = '{3, 1};
    int hp[2] = '{1, 1};
    int mode[2] = '{0, 0};
    int e[2] = '{0, 0};
    logic pend[2] = '{1'b0, 1'b0};
    logic [7:0] dm[2] = '{8'h00, 8'h00};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mode[i] = 0; e[i] = 0; pend[i] = 1'b0; dm[i] = 8'h00;
            end else if (mode[i] == 0) begin
                if (pend[i] || creq[i]) begin
                    mode[i] = 2; e[i] = 0; pend[i] = 1'b0;
                end else if (vin[i]) begin
                    mode[i] = 1; e[i] = 0; dm[i] = din[i];
                end
            end else begin
                pend[i] = pend[i] | creq[i];
                e[i] = e[i] + 1;
                if ((mode[i] == 1 && e[i] == sp[i] + pp[i] + hp[i]) || (mode[i] == 2 && e[i] == pp[i])) mode[i] = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.d", i), dq[i], dm[i]);
            chk($sformatf("u%0d.g", i), gq[i], int'(mode[i] == 1 && e[i] >= sp[i] && e[i] < sp[i] + pp[i]));
            chk($sformatf("u%0d.clr", i), cq[i], int'(mode[i] == 2));
            chk($sformatf("u%0d.busy", i), bq[i], int'(mode[i] != 0));
            chk($sformatf("u%0d.in_ready", i), rdy[i], int'(mode[i] == 0 && !pend[i] && !creq[i] && !rst));
            chk($sformatf("u%0d.g_and_clr", i), int'(gq[i] && cq[i]), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n, ng, nc;
        logic [6:0] gexp;
        for (int i = 0; i < 2; i++) begin
            din[i] = 8'h00; vin[i] = 1'b0; creq[i] = 1'b0;
        end
        repeat (2) tick();
        chk("ready_in_reset", rdy[0], 0);
        rst = 1'b0;
        #1 chk("ready_after_reset", rdy[0], 1);
        chk("d_after_reset", dq[0], 0);
        tick();

        // single transfer of 0x3C
        din[0] = 8'h3C; vin[0] = 1'b1;
        tick();
        vin[0] = 1'b0; din[0] = 8'hEE;
        gexp = 7'b0011100;
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("single_g_k%0d", k), gq[0], int'(gexp[k]));
            chk($sformatf("single_d_k%0d", k), dq[0], 8'h3C);
            if (k < 6) tick();
        end
        chk("single_ready_k6", rdy[0], 1);
        chk("single_busy_k6", bq[0], 0);

        // back-to-back 0x11, 0x22
        din[0] = 8'h11; vin[0] = 1'b1;
        tick();
        din[0] = 8'h22;
        n = 0;
        while (dq[0] != 8'h22 && n < 20) begin tick(); n++; end
        chk("b2b_spacing", n, 7);
        vin[0] = 1'b0;
        repeat (7) tick();

        // clear has priority over a simultaneous word
        din[0] = 8'h55; vin[0] = 1'b1; creq[0] = 1'b1;
        #1 chk("clrprio_ready", rdy[0], 0);
        tick();
        creq[0] = 1'b0;
        chk("clrprio_clr_k0", cq[0], 1);
        chk("clrprio_d_k0", dq[0], 8'h22);
        tick(); tick();
        chk("clrprio_clr_k2", cq[0], 1);
        tick();
        chk("clrprio_clr_k3", cq[0], 0);
        chk("clrprio_ready_k3", rdy[0], 1);
        tick();
        chk("clrprio_d_k4", dq[0], 8'h55);
        vin[0] = 1'b0;
        repeat (7) tick();

        // clear requested mid-GATE waits for the transfer
        din[0] = 8'h77; vin[0] = 1'b1;
        tick();
        vin[0] = 1'b0;
        tick(); tick();
        chk("midgate_g", gq[0], 1);
        creq[0] = 1'b1;
        ng = int'(gq[0]); nc = 0;
        tick();
        creq[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            ng += int'(gq[0]); nc += int'(cq[0]);
            tick();
        end
        chk("midgate_g_cycles", ng, 3);
        chk("midgate_clr_cycles", nc, 3);

        // asynchronous reset mid-GATE
        din[0] = 8'hA5; vin[0] = 1'b1;
        tick();
        vin[0] = 1'b0;
        tick(); tick();
        chk("rst_pre_g", gq[0], 1);
        chk("rst_pre_d", dq[0], 8'hA5);
        #1 rst = 1'b1;
        #1 chk("rst_g", gq[0], 0);
        chk("rst_d", dq[0], 0);
        chk("rst_clr", cq[0], 0);
        chk("rst_ready", rdy[0], 0);
        repeat (3) tick();
        chk("rst_ready_held", rdy[0], 0);
        rst = 1'b0;
        #1 chk("rst_ready_release", rdy[0], 1);
        tick();

        // SETUP=PULSE=HOLD=1 corner
        din[1] = 8'hFF; vin[1] = 1'b1;
        tick();
        chk("corner_d_ff", dq[1], 8'hFF);
        din[1] = 8'h00;
        n = 0; ng = 0;
        while (dq[1] != 8'h00 && n < 20) begin ng += int'(gq[1]); tick(); n++; end
        chk("corner_spacing", n, 4);
        chk("corner_g_cycles", ng, 1);
        vin[1] = 1'b0;
        ng = 0;
        for (int k = 0; k < 5; k++) begin ng += int'(gq[1]); tick(); end
        chk("corner_g_cycles2", ng, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
